// File: rtl/timer_countdown.sv
// BCD mm:ss countdown timer feeding mag_control; keypad digits shift in from the right.
// Optional end-of-cook beep pulse is built only when TIMER_BEEP_EN is defined.
module timer_countdown #(
  parameter int unsigned TICK_DIV    = 100,
  parameter int unsigned BEEP_CYCLES = 50
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       mag_on,
  output logic       timer_done,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       beep
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nx;
  logic [3:0]    min_tens_nx;
  logic [3:0]    min_ones_nx;
  logic [3:0]    sec_tens_nx;
  logic [3:0]    sec_ones_nx;
  logic          key_ok;
  logic          run;
  logic          tick;
  logic          tick_to_zero;

  assign timer_done = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_ones == 4'd0);

  assign key_ok       = key_valid && !mag_on && (key_digit <= 4'd9);
  assign run          = mag_on && !timer_done;
  assign tick         = run && (presc == PW'(TICK_DIV - 1));
  assign tick_to_zero = tick && (min_tens == 4'd0) && (min_ones == 4'd0) &&
                        (sec_tens == 4'd0) && (sec_ones == 4'd1);

  // Next count: key shift-in, or one-second BCD decrement with borrow chain
  always_comb begin
    min_tens_nx = min_tens;
    min_ones_nx = min_ones;
    sec_tens_nx = sec_tens;
    sec_ones_nx = sec_ones;
    presc_nx    = presc;
    if (key_ok) begin
      min_tens_nx = min_ones;
      min_ones_nx = sec_tens;
      sec_tens_nx = sec_ones;
      sec_ones_nx = key_digit;
      presc_nx    = '0;
    end else if (run) begin
      if (tick) begin
        presc_nx = '0;
        if (sec_ones != 4'd0) begin
          sec_ones_nx = sec_ones - 4'd1;
        end else if (sec_tens != 4'd0) begin
          sec_ones_nx = 4'd9;
          sec_tens_nx = sec_tens - 4'd1;
        end else begin
          sec_ones_nx = 4'd9;
          sec_tens_nx = 4'd5;
          if (min_ones != 4'd0) begin
            min_ones_nx = min_ones - 4'd1;
          end else begin
            min_ones_nx = 4'd9;
            min_tens_nx = min_tens - 4'd1;
          end
        end
      end else begin
        presc_nx = presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      presc    <= '0;
    end else begin
      min_tens <= min_tens_nx;
      min_ones <= min_ones_nx;
      sec_tens <= sec_tens_nx;
      sec_ones <= sec_ones_nx;
      presc    <= presc_nx;
    end
  end

`ifdef TIMER_BEEP_EN
  localparam int unsigned BW = $clog2(BEEP_CYCLES + 1);

  logic [BW-1:0] beep_cnt;
  logic [BW-1:0] beep_cnt_nx;

  // Loaded by the tick that lands on 00:00; later key entries do not disturb it
  always_comb begin
    beep_cnt_nx = beep_cnt;
    if (tick_to_zero) begin
      beep_cnt_nx = BW'(BEEP_CYCLES);
    end else if (beep_cnt != '0) begin
      beep_cnt_nx = beep_cnt - BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      beep_cnt <= '0;
    end else begin
      beep_cnt <= beep_cnt_nx;
    end
  end

  assign beep = (beep_cnt != '0);
`else
  logic unused_beep;
  assign unused_beep = &{1'b0, tick_to_zero, BEEP_CYCLES[0]};
  assign beep        = 1'b0;
`endif

endmodule

// File: tb/tb_timer_countdown.sv
// Randomized and directed bench for timer_countdown against a minutes/seconds arithmetic model.
module tb_timer_countdown;

  localparam int unsigned TICK_DIV    = 4;
  localparam int unsigned BEEP_CYCLES = 3;
`ifdef TIMER_BEEP_EN
  localparam bit BEEP_EN = 1'b1;
`else
  localparam bit BEEP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       mag_on = 1'b0;
  logic       timer_done;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       beep;

  int n_cmp = 0;
  int n_bad = 0;

  timer_countdown #(.TICK_DIV(TICK_DIV), .BEEP_CYCLES(BEEP_CYCLES)) dut (
    .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_digit(key_digit),
    .mag_on(mag_on), .timer_done(timer_done), .min_tens(min_tens),
    .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones), .beep(beep)
  );

  always #5 clk = ~clk;

  // Model: minutes and seconds as plain integers (seconds may exceed 59 when keyed in)
  int  m_min = 0;
  int  m_sec = 0;
  int  m_ph = 0;
  int  m_beep = 0;
  bit  m_valid = 1'b0;

  always @(posedge clk) begin
    int v;
    if (!clrn) begin
      m_min = 0; m_sec = 0; m_ph = 0; m_beep = 0; m_valid = 1'b1;
    end else begin
      if (m_beep > 0) m_beep = m_beep - 1;
      if (key_valid && !mag_on && key_digit <= 4'd9) begin
        v = ((m_min * 100 + m_sec) * 10 + int'(key_digit)) % 10000;
        m_min = v / 100;
        m_sec = v % 100;
        m_ph = 0;
      end else if (mag_on && (m_min + m_sec) != 0) begin
        m_ph = m_ph + 1;
        if (m_ph == TICK_DIV) begin
          m_ph = 0;
          if (m_sec > 0) m_sec = m_sec - 1;
          else begin m_sec = 59; m_min = m_min - 1; end
          if (BEEP_EN && m_min == 0 && m_sec == 0) m_beep = BEEP_CYCLES;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [15:0] exp_d, got_d;
    logic        exp_done, exp_beep;
    if (m_valid) begin
      exp_d    = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
      got_d    = {min_tens, min_ones, sec_tens, sec_ones};
      exp_done = (m_min == 0 && m_sec == 0);
      exp_beep = (m_beep > 0);
      n_cmp++;
      if (got_d !== exp_d || timer_done !== exp_done || beep !== exp_beep) begin
        n_bad++;
        $display("FAIL model t=%0t: got %h done=%b beep=%b, expected %h done=%b beep=%b",
                 $time, got_d, timer_done, beep, exp_d, exp_done, exp_beep);
      end
    end
  end

  task automatic check_lit(input string name, input logic [15:0] exp_d,
                           input logic exp_done, input logic exp_beep);
    logic [15:0] got_d;
    got_d = {min_tens, min_ones, sec_tens, sec_ones};
    n_cmp++;
    if (got_d !== exp_d || timer_done !== exp_done || beep !== exp_beep) begin
      n_bad++;
      $display("FAIL %s: got %h done=%b beep=%b, expected %h done=%b beep=%b",
               name, got_d, timer_done, beep, exp_d, exp_done, exp_beep);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    cyc(2);
    clrn = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check_lit("reset", 16'h0000, 1'b1, 1'b0);

    // Digit entry and filtering
    key(4'd1); key(4'd2); key(4'd3); key(4'd0);
    check_lit("entry_1230", 16'h1230, 1'b0, 1'b0);
    key(4'hC);
    check_lit("entry_ignore_C", 16'h1230, 1'b0, 1'b0);

    // Basic countdown 00:02
    do_reset();
    key(4'd2);
    check_lit("entry_0002", 16'h0002, 1'b0, 1'b0);
    mag_on = 1'b1;
    cyc(3);
    check_lit("pre_tick", 16'h0002, 1'b0, 1'b0);
    cyc(1);
    check_lit("tick1", 16'h0001, 1'b0, 1'b0);
    cyc(4);
    check_lit("tick2_done", 16'h0000, 1'b1, BEEP_EN);
    cyc(2);
    check_lit("beep_hold", 16'h0000, 1'b1, BEEP_EN);
    cyc(1);
    check_lit("beep_end", 16'h0000, 1'b1, 1'b0);
    mag_on = 1'b0;

    // Borrow chain
    do_reset();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    mag_on = 1'b1; cyc(4); mag_on = 1'b0;
    check_lit("borrow_1000", 16'h0959, 1'b0, 1'b0);
    do_reset();
    key(4'd7); key(4'd5);
    mag_on = 1'b1; cyc(4); mag_on = 1'b0;
    check_lit("sec_tens_75", 16'h0074, 1'b0, 1'b0);

    // Pause and resume, key ignored while running
    do_reset();
    key(4'd5);
    mag_on = 1'b1; cyc(2);
    mag_on = 1'b0; cyc(10);
    check_lit("paused", 16'h0005, 1'b0, 1'b0);
    mag_on = 1'b1; cyc(1);
    check_lit("resume_3rd", 16'h0005, 1'b0, 1'b0);
    cyc(1);
    check_lit("resume_4th", 16'h0004, 1'b0, 1'b0);
    key(4'd9);
    check_lit("key_while_on", 16'h0004, 1'b0, 1'b0);
    mag_on = 1'b0;

    // Reset mid-countdown
    do_reset();
    key(4'd1); key(4'd0); key(4'd0);
    mag_on = 1'b1; cyc(5);
    check_lit("run_0100", 16'h0059, 1'b0, 1'b0);
    clrn = 1'b0; cyc(1);
    check_lit("reset_mid", 16'h0000, 1'b1, 1'b0);
    clrn = 1'b1; mag_on = 1'b0;

    // Randomized traffic; per-cycle model compare does the checking
    for (int i = 0; i < 4000; i++) begin
      key_valid = ($urandom_range(0, 5) == 0);
      key_digit = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) mag_on = ~mag_on;
      clrn = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    key_valid = 1'b0; clrn = 1'b1; mag_on = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_countdown.md
# timer_countdown

BCD minutes:seconds countdown timer for the microwave oven. It sits directly upstream of `mag_control`. Keypad digits set the cook time, and the timer counts down once per second while `mag_on` is high. Its `timer_done` output drives the `timer_done` input of `mag_control`, so the magnetron shuts off when the count reaches 00:00.

## Interface
Parameters:
- `TICK_DIV`, default 100: `clk` cycles per one-second tick; legal range ≥2.
- `BEEP_CYCLES`, default 50: length of the end-of-cook beep pulse, in cycles; legal range ≥1.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `clrn` in 1: synchronous, active-low reset and clear.
- `key_valid` in 1: one-cycle strobe; a digit is present on `key_digit`.
- `key_digit` in 4: BCD keypad digit.
- `mag_on` in 1: fed back from `mag_control`; enables the countdown.
- `timer_done` out 1: high whenever the count equals 00:00.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` out 4 each: registered BCD display digits.
- `beep` out 1: end-of-cook pulse.

## Operation
- **Reset** (`clrn`=0 at a clock edge):
  - All digits = 0.
  - Prescaler = 0.
  - Beep counter = 0, so `beep`=0.
  - `timer_done`=1 (it decodes from a zero count).
  - Reset overrides every other input in the same cycle, including mid-countdown.
- **Digit entry:** accepted only when `key_valid`=1, `mag_on`=0 and `key_digit`≤9.
  - Digits shift left: `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`key_digit`.
  - The old `min_tens` is discarded.
  - The prescaler clears to 0.
  - Ignored cases: `key_digit` 10–15 is ignored; `key_valid` while `mag_on`=1 is ignored.
- **Prescaler:** advances only when `mag_on`=1 and the count ≠ 00:00.
  - At `TICK_DIV`-1 it wraps to 0 and issues a tick.
  - While `mag_on`=0 it holds its value, so a paused partial second resumes where it stopped.
- **Tick:** decrements the four-digit BCD count by one second.
  - `sec_ones` counts 9→0; the 0 case borrows from `sec_tens`.
  - When `sec_tens`=`sec_ones`=0, the seconds reload to 5,9 and the minutes decrement. `min_ones` 0 borrows from `min_tens`, reloading to 9.
  - Entered `sec_tens` values above 5 are legal and count down naturally. Example: 00:75 → 00:74 → … → 00:60 → 00:59.
  - Decrement from 00:00 never occurs; the prescaler is gated off at zero.
- **`timer_done`:** combinational decode of all four digit registers being 0; no extra register stage.
- **Beep:** the tick that produces 00:00 loads the beep counter with `BEEP_CYCLES`.
  - `beep`=1 while the counter is nonzero; the counter decrements each cycle.
  - Reaching 00:00 by reset never beeps.
  - A key entry during the beep does not cut it short.

## Timing
- **Key entry:** a digit accepted at edge N appears on the display outputs after edge N.
- **First tick:** with prescaler=0 and `mag_on` rising before edge 0, the first decrement is visible after edge `TICK_DIV`-1, i.e. after `TICK_DIV` enabled cycles. Subsequent ticks follow every `TICK_DIV` enabled cycles.
- **Done and beep:** `timer_done` and `beep` rise together, in the same cycle the count register becomes 00:00.
- **Beep length:** `beep` lasts exactly `BEEP_CYCLES` cycles.
- **Loop to `mag_control`:** `mag_control` drops `mag_on` in response to `timer_done`. Any `mag_on`=1 cycles at zero count are harmless, because the prescaler is gated.
- **Mid-second drop of `mag_on`:** the count freezes. No tick is lost or duplicated.

## Configuration
- `TIMER_BEEP_EN` defined:
  - The beep counter and its logic are built.
  - `beep` behaves as described under Operation and Timing.
- `TIMER_BEEP_EN` undefined:
  - No beep counter is built.
  - `beep` is tied to 0.
  - All other behaviour is identical.

## Test plan
Benches use `TICK_DIV`=4 and `BEEP_CYCLES`=3.

- **Reset values:** hold `clrn`=0 for 2 cycles → all digits 0, `timer_done`=1, `beep`=0.
- **Digit entry and filtering:** enter keys 1,2,3,0 → display 12:30, `timer_done`=0. Then enter key 4'hC → display unchanged.
- **Basic countdown:** entry 00:02, then `mag_on`=1 → 00:01 after 4 cycles, 00:00 after 8 cycles. `timer_done`=1 in the same cycle as 00:00. `beep`=1 for exactly 3 cycles (macro defined) or stays 0 (macro undefined).
- **Borrow chain:** entry 10:00, run one tick → 09:59. Separately, entry 00:75 → 00:74.
- **Pause and resume:** `mag_on` high 2 cycles, low 10 cycles, high 2 cycles → exactly one decrement, on the 4th enabled cycle. A key pressed while `mag_on`=1 is ignored.
- **Reset mid-countdown:** `clrn` low during a running 01:00 countdown → 00:00 next edge, `timer_done`=1, `beep`=0.
